// File: rtl/message_display_mux.sv
// Time-multiplexed 7-segment driver: scan counter, loadable display register,
// built-in character ROM, blink and blank modes.
module message_display_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int CHAR_W         = 5,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLINK_DIV      = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_DIGITS*CHAR_W-1:0] chars,
  input  logic                         load,
  input  logic                         enable,
  input  logic                         blink_en,
  output logic [6:0]                   seg,
  output logic [NUM_DIGITS-1:0]        dig,
  output logic                         frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BD_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic POL = (SEG_ACTIVE_LOW != 0);

  logic [PS_W-1:0]       prescale_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [CHAR_W-1:0]     disp_reg [NUM_DIGITS];
  logic                  wrap_reg;
  logic                  frame_tick_reg;
  logic [BD_W-1:0]       frame_cnt_reg;
  logic                  phase_reg;
  logic [6:0]            seg_reg;
  logic [NUM_DIGITS-1:0] dig_reg;

  logic                  slot_end;
  logic                  idx_last;
  logic                  blink_wrap;
  logic                  phase_next;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_next;

  function automatic logic [6:0] glyph(input logic [CHAR_W-1:0] code);
    logic [6:0] g;
    g = 7'b0000000;
    case (int'(code))
      0:       g = 7'b1111110;
      1:       g = 7'b0110000;
      2:       g = 7'b1101101;
      3:       g = 7'b1111001;
      4:       g = 7'b0110011;
      5:       g = 7'b1011011;
      6:       g = 7'b1011111;
      7:       g = 7'b1110000;
      8:       g = 7'b1111111;
      9:       g = 7'b1111011;
      10:      g = 7'b1110111;
      11:      g = 7'b1001110;
      12:      g = 7'b1001111;
      13:      g = 7'b1000111;
      14:      g = 7'b1100111;
      15:      g = 7'b0001110;
      16:      g = 7'b0000001;
      17:      g = 7'b1011011;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  assign slot_end   = (prescale_reg == PS_W'(PRESCALE - 1));
  assign idx_last   = (idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign blink_wrap = wrap_reg && (frame_cnt_reg == BD_W'(BLINK_DIV - 1));
  // Using the post-edge phase lets blanking start exactly on the frame boundary.
  assign phase_next = phase_reg ^ blink_wrap;

  always_comb begin
    seg_next = {7{POL}};
    dig_next = {NUM_DIGITS{POL}};
    if (enable && !(blink_en && phase_next)) begin
      seg_next = glyph(disp_reg[idx_reg]) ^ {7{POL}};
      dig_next = (NUM_DIGITS'(1) << idx_reg) ^ {NUM_DIGITS{POL}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_reg   <= '0;
      idx_reg        <= '0;
      wrap_reg       <= 1'b0;
      frame_tick_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      phase_reg      <= 1'b0;
      seg_reg        <= {7{POL}};
      dig_reg        <= {NUM_DIGITS{POL}};
    end else begin
      if (slot_end) begin
        prescale_reg <= '0;
        idx_reg      <= idx_last ? '0 : idx_reg + 1'b1;
      end else begin
        prescale_reg <= prescale_reg + 1'b1;
      end
      // Two-stage pulse so frame_tick lines up with the output register showing digit 0.
      wrap_reg       <= slot_end && idx_last;
      frame_tick_reg <= wrap_reg;
      if (wrap_reg) begin
        frame_cnt_reg <= blink_wrap ? '0 : frame_cnt_reg + 1'b1;
      end
      phase_reg <= phase_next;
      seg_reg   <= seg_next;
      dig_reg   <= dig_next;
    end
  end

  // Display register captures independently of the scan, so load never disturbs idx.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_disp
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          disp_reg[gi] <= '1;
        end else if (load) begin
          disp_reg[gi] <= chars[gi*CHAR_W +: CHAR_W];
        end
      end
    end
  endgenerate

  assign seg        = seg_reg;
  assign dig        = dig_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_message_display_mux.sv
// Self-checking bench: cycle-indexed behavioural model plus directed literal checks.
module tb_message_display_mux;

  localparam int ND = 4;
  localparam int P  = 4;
  localparam int CW = 5;
  localparam int BD = 2;
  localparam int FRAME = P * ND;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ND*CW-1:0]  chars = '0;
  logic              load = 1'b0;
  logic              enable = 1'b1;
  logic              blink_en = 1'b0;
  logic [6:0]        seg;
  logic [ND-1:0]     dig;
  logic              frame_tick;

  int checks = 0;
  int failures = 0;
  bit check_on = 1'b0;

  message_display_mux #(
    .NUM_DIGITS(ND), .PRESCALE(P), .CHAR_W(CW), .SEG_ACTIVE_LOW(1), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chars(chars), .load(load), .enable(enable),
    .blink_en(blink_en), .seg(seg), .dig(dig), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Model: k counts clock edges since reset release; everything follows from k.
  int         k = 0;
  logic [4:0] disp_m [ND];
  logic [6:0] exp_seg = 7'h7F;
  logic [3:0] exp_dig = 4'hF;
  logic       exp_ft = 1'b0;

  function automatic logic [6:0] glyph_m(input int c);
    logic [6:0] t [18];
    t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B,
          7'h77, 7'h4E, 7'h4F, 7'h47, 7'h67, 7'h0E, 7'h01, 7'h5B};
    return (c < 18) ? t[c] : 7'h00;
  endfunction

  function automatic int slot_at(input int kk);
    return ((kk - 1) / P) % ND;
  endfunction

  function automatic bit lit_at(input int kk, input logic en, input logic bl);
    int frames;
    frames = (kk - 1) / FRAME;
    return en && !(bl && ((frames / BD) % 2 == 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= 0;
      for (int i = 0; i < ND; i++) disp_m[i] <= 5'h1F;
      exp_seg <= 7'h7F;
      exp_dig <= 4'hF;
      exp_ft  <= 1'b0;
    end else begin
      k       <= k + 1;
      exp_ft  <= (k > 0) && (k % FRAME == 0);
      exp_dig <= lit_at(k + 1, enable, blink_en) ? ~(4'b0001 << slot_at(k + 1)) : 4'hF;
      exp_seg <= lit_at(k + 1, enable, blink_en) ? ~glyph_m(int'(disp_m[slot_at(k + 1)])) : 7'h7F;
      if (load) for (int i = 0; i < ND; i++) disp_m[i] <= chars[i*CW +: CW];
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (check_on) begin
      chk("model_seg", 32'(seg), 32'(exp_seg));
      chk("model_dig", 32'(dig), 32'(exp_dig));
      chk("model_frame_tick", 32'(frame_tick), 32'(exp_ft));
    end
  end

  task automatic do_load(input logic [ND*CW-1:0] v);
    @(negedge clk);
    chars = v;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load chars=%h", v);
    @(negedge clk);
  endtask

  task automatic wait_dig(input logic [3:0] d, input string name);
    int n = 0;
    while (dig !== d && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(dig), 32'(d));
  endtask

  task automatic tick_spacing(input string name);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_first"}, 32'(frame_tick), 32'd1);
    chk({name, "_dig"}, 32'(dig === 4'hF || dig === 4'b1110), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    chk({name, "_spacing"}, 32'(n), 32'd16);
  endtask

  task automatic mid_reset(input string name);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk({name, "_seg"}, 32'(seg), 32'h7F);
    chk({name, "_dig"}, 32'(dig), 32'hF);
    chk({name, "_ft"}, 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk({name, "_release_dig"}, 32'(dig), 32'b1110);
  endtask

  initial begin
    int blanks;
    // Reset assertion mid-slot, checked between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dig", 32'(dig), 32'hF);
    chk("reset_ft", 32'(frame_tick), 32'd0);
    check_on = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_dig", 32'(dig), 32'b1110);
    chk("release_seg_blank", 32'(seg), 32'h7F);

    // "CE01"
    do_load({5'd11, 5'd12, 5'd0, 5'd1});
    wait_dig(4'b1101, "ce01_dig1");
    chk("ce01_seg1", 32'(seg), 32'h01);
    wait_dig(4'b1011, "ce01_dig2");
    chk("ce01_seg2", 32'(seg), 32'h30);
    wait_dig(4'b0111, "ce01_dig3");
    chk("ce01_seg3", 32'(seg), 32'h31);
    wait_dig(4'b1110, "ce01_dig0");
    chk("ce01_seg0", 32'(seg), 32'h4F);

    tick_spacing("freerun");
    chk("freerun_tick_dig0", 32'(dig), 32'b1110);

    // Blink: over any 128-cycle window exactly half the cycles are blanked.
    blink_en = 1'b1;
    blanks = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (dig === 4'hF) blanks++;
    end
    chk("blink_blank_count", 32'(blanks), 32'd64);
    blink_en = 1'b0;
    repeat (70) @(negedge clk);

    // Enable drop during digit 2, then resume.
    wait_dig(4'b1101, "en_pre_dig1");
    wait_dig(4'b1011, "en_pre_dig2");
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_seg", 32'(seg), 32'h7F);
    chk("disable_dig", 32'(dig), 32'hF);
    tick_spacing("disabled");
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_lit", 32'(dig !== 4'hF), 32'd1);
    tick_spacing("reenabled");

    // Unknown code renders blank while the anode is still driven.
    do_load({5'd11, 5'd12, 5'd30, 5'd1});
    wait_dig(4'b1101, "code30_dig");
    chk("code30_seg", 32'(seg), 32'h7F);

    // Load on the edge where idx moves from digit 2 to digit 3.
    wait_dig(4'b1011, "slotchg_dig2");
    repeat (2) @(negedge clk);
    chars = {5'd16, 5'd12, 5'd30, 5'd1};
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load chars=%h", chars);
    chk("slotchg_old_dig", 32'(dig), 32'b1011);
    @(negedge clk);
    chk("slotchg_new_dig", 32'(dig), 32'b0111);
    chk("slotchg_new_seg", 32'(seg), 32'h7E);

    // Loads at assorted scan offsets, checked by the model.
    for (int o = 0; o < 5; o++) begin
      repeat (o) @(negedge clk);
      do_load({5'(o + 2), 5'(17 - o), 5'(10 + o), 5'(o * 3)});
      repeat (9) @(negedge clk);
    end

    mid_reset("midreset");
    repeat (3) @(negedge clk);
    chk("midreset_disp_blank", 32'(seg), 32'h7F);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
